if_fetch_stage: RTL and testbench

Instruction-fetch stage of the 8-bit pipelined core; sits directly upstream of the IF/ID pipeline register and drives its instrCode, pc and flush inputs.
- Holds the program counter and a writable instruction memory, loaded through a side port before run.
- Increments the PC each cycle, holds it on stall, redirects it on a jump resolved in ID, and squashes the wrong-path fetch.
- A fetched HALT opcode parks the stage until a jump or reset.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/imem_rf.sv | 51 +++++
 rtl/if_fetch_stage.sv | 92 +++++++++
 tb/tb_if_fetch_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the 8-bit pipelined core.
//   PC_W / INSTR_W   : program counter and instruction widths
//   HALT_OP / NOP_OP : opcodes the fetch stage treats specially
//   fetch_state_t    : fetch stage FSM states
package cpu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 8;

  localparam logic [INSTR_W-1:0] HALT_OP = 8'hFF;
  localparam logic [INSTR_W-1:0] NOP_OP  = 8'h00;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/imem_rf.sv
// imem_rf
// Writable instruction memory for the fetch stage.
//   clk, rst  : clock (rising edge), asynchronous active-low reset that
//               clears every entry to zero
//   we        : write enable
//   waddr     : write address (AW bits)
//   wdata     : write data
//   raddr     : full-width PC used as read address
//   rdata     : combinational read data, NOP_OP when raddr is out of range
//   fault     : raddr lies at or beyond DEPTH
module imem_rf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [PC_W-1:0]    raddr,
  output logic [INSTR_W-1:0] rdata,
  output logic               fault
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Reset wipes the whole program so a stale image can never run after
  // a mid-operation reset; the loader has to fill it again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= NOP_OP;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // DEPTH is a power of two, so any set bit above the index field
  // means the PC points past the end of the array.
  if (AW < PC_W) begin : g_partial
    assign fault = |raddr[PC_W-1:AW];
  end else begin : g_full
    assign fault = 1'b0;
  end

  assign rdata = fault ? NOP_OP : mem[raddr[AW-1:0]];

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID pipeline register.
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   stall        : hold PC and output (load-use hazard from ID)
//   jump_en      : redirect request resolved in ID
//   jump_target  : redirect address
//   load_en      : instruction memory write enable (pauses fetch)
//   load_addr    : instruction memory write address
//   load_data    : instruction memory write data
//   instrCode    : fetched instruction, NOP while halted
//   pc           : address of instrCode
//   flush        : squash IF/ID at this edge (combinational)
//   halted       : stage parked on a HALT opcode
//   imem_fault   : pc is beyond the instruction memory
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter int              IMEM_DEPTH = 32,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              AW         = $clog2(IMEM_DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               load_en,
  input  logic [AW-1:0]      load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic [INSTR_W-1:0] instrCode,
  output logic [PC_W-1:0]    pc,
  output logic               flush,
  output logic               halted,
  output logic               imem_fault
);

  fetch_state_t       state, state_next;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [INSTR_W-1:0] fetched;

  imem_rf #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk   (clk),
    .rst   (rst),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_reg),
    .rdata (fetched),
    .fault (imem_fault)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
      state  <= RUN;
    end else begin
      pc_reg <= pc_next;
      state  <= state_next;
    end
  end

  // Loading owns the cycle outright, then a jump beats a stall so the
  // wrong-path fetch is squashed even during a hazard hold. A fetched
  // HALT keeps its own PC so it is presented to IF/ID exactly once.
  always_comb begin
    pc_next    = pc_reg;
    state_next = state;
    if (load_en) begin
      pc_next    = pc_reg;
    end else if (jump_en) begin
      pc_next    = jump_target;
      state_next = RUN;
    end else if (stall) begin
      pc_next    = pc_reg;
    end else if (state == RUN) begin
      if (fetched == HALT_OP) begin
        state_next = HALT;
      end else begin
        pc_next = pc_reg + 1'b1;
      end
    end
  end

  assign pc        = pc_reg;
  assign halted    = (state == HALT);
  assign instrCode = (state == HALT) ? NOP_OP : fetched;
  assign flush     = jump_en & ~load_en;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage
// Scoreboard bench for if_fetch_stage: stimulus tasks push the outputs the
// reference model predicts for each cycle, a negedge monitor pops and
// compares them against the DUT.
module tb_if_fetch_stage;

  localparam int DEPTH = 32;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       jump_en;
  logic [7:0] jump_target;
  logic       load_en;
  logic [4:0] load_addr;
  logic [7:0] load_data;
  logic [7:0] instrCode;
  logic [7:0] pc;
  logic       flush;
  logic       halted;
  logic       imem_fault;

  if_fetch_stage #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_target (jump_target),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .instrCode   (instrCode),
    .pc          (pc),
    .flush       (flush),
    .halted      (halted),
    .imem_fault  (imem_fault)
  );

  typedef struct {
    logic [7:0] instr;
    logic [7:0] pc;
    logic       flush;
    logic       halted;
    logic       fault;
  } exp_t;

  exp_t sb[$];

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: program array, PC as an integer, halted flag.
  int   mPc;
  bit   mHalted;
  int   mMem [DEPTH];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int memRead(input int addr);
    return (addr < DEPTH) ? mMem[addr] : 0;
  endfunction

  task automatic pushExpected(input bit ld, input bit jmp);
    exp_t e;
    e.instr  = mHalted ? 8'h00 : 8'(memRead(mPc));
    e.pc     = 8'(mPc);
    e.flush  = jmp && !ld;
    e.halted = mHalted;
    e.fault  = (mPc >= DEPTH);
    sb.push_back(e);
  endtask

  task automatic modelReset();
    mPc     = 0;
    mHalted = 0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = 0;
  endtask

  // One clock edge of the fetch rules, highest priority first.
  task automatic modelStep(input bit ld, input int la, input int ld_data,
                           input bit jmp, input int jt, input bit stl);
    if (ld) begin
      mMem[la] = ld_data;
    end else if (jmp) begin
      mPc     = jt;
      mHalted = 0;
    end else if (stl) begin
      mPc = mPc;
    end else if (!mHalted) begin
      if (memRead(mPc) == 8'hFF) mHalted = 1;
      else mPc = (mPc + 1) % 256;
    end
  endtask

  task automatic applyStimulus(input bit ld, input logic [4:0] la, input logic [7:0] ldat,
                               input bit jmp, input logic [7:0] jt, input bit stl);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    load_en     = ld;
    load_addr   = la;
    load_data   = ldat;
    jump_en     = jmp;
    jump_target = jt;
    stall       = stl;
    pushExpected(ld, jmp);
    modelStep(ld, int'(la), int'(ldat), jmp, int'(jt), stl);
  endtask

  task automatic applyReset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      rst         = 1'b0;
      load_en     = 1'b0;
      jump_en     = 1'b0;
      stall       = 1'b0;
      load_addr   = '0;
      load_data   = '0;
      jump_target = '0;
      modelReset();
      pushExpected(1'b0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic load(input int a, input int d);
    applyStimulus(1'b1, 5'(a), 8'(d), 1'b0, 8'h00, 1'b0);
  endtask

  task automatic jump(input int t, input bit stl);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b1, 8'(t), stl);
  endtask

  // Monitor: every mid-cycle sample consumes one prediction.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("instrCode",  instrCode,        e.instr);
      checkOutput("pc",         pc,               e.pc);
      checkOutput("flush",      8'(flush),        8'(e.flush));
      checkOutput("halted",     8'(halted),       8'(e.halted));
      checkOutput("imem_fault", 8'(imem_fault),   8'(e.fault));
    end
  end

  initial begin
    rst = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_target = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    modelReset();

    $display("[TB] reset and program load");
    applyReset(2);
    load(0, 8'h11); load(1, 8'h22); load(2, 8'h33); load(3, 8'h44);
    idle(4);

    $display("[TB] stall hold");
    jump(0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(1'b0, 5'd0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(2);

    $display("[TB] jump redirect, plain and with stall");
    jump(1, 1'b0); idle(1);
    jump(8'h10, 1'b0); idle(2);
    jump(1, 1'b0); idle(1);
    jump(8'h10, 1'b1); idle(2);

    $display("[TB] halt opcode");
    load(5, 8'hFF);
    jump(0, 1'b0);
    idle(9);
    applyStimulus(1'b1, 5'd4, 8'h55, 1'b1, 8'h03, 1'b0);
    jump(0, 1'b1);
    idle(3);

    $display("[TB] out-of-range fetch and PC wrap");
    jump(8'h1F, 1'b0);
    idle(230);

    $display("[TB] mid-run reset");
    for (int i = 0; i < 8; i++) load(i, 8'h30 + i);
    jump(0, 1'b0);
    idle(7);
    applyReset(2);
    idle(2);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 500; n++) begin
      int r;
      bit ld, jmp, stl;
      logic [7:0] ldat;
      r    = int'($urandom_range(0, 99));
      ld   = (r < 12);
      jmp  = (r >= 12 && r < 24) || ($urandom_range(0, 9) == 0);
      stl  = ($urandom_range(0, 6) == 0);
      ldat = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 199) == 0) begin
        applyReset(1);
      end else begin
        applyStimulus(ld, 5'($urandom_range(0, 31)), ldat, jmp,
                      ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 40)),
                      stl);
      end
    end

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
